// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder: accepts a word on a valid/ready handshake and shifts out L bits, one per clock.
// Optional even-parity trailer bit is built in when the SER_PARITY_EN macro is defined.
module seq_bit_serializer #(
  parameter int DATA_W     = 8,
  parameter bit MSB_FIRST  = 1,
  parameter bit IDLE_LEVEL = 0,
  parameter int LEN_W      = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              serial_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              done
);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
  localparam logic [LEN_W-1:0] TWO      = LEN_W'(2);

  state_t            state, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [LEN_W-1:0]  bit_cnt, cnt_next;
  logic              serial_next, valid_next, busy_next, done_next;

  logic [LEN_W-1:0]  eff_len;
  logic [LEN_W-1:0]  pad;
  logic [DATA_W-1:0] len_mask;
  logic [DATA_W-1:0] masked;
  logic [DATA_W-1:0] aligned;
  logic [DATA_W-1:0] shifted;
  logic              last_bit;
  logic              ready_slot;
  logic              accept;

`ifdef SER_PARITY_EN
  logic parity_reg, parity_next;
`endif

  // The shift register holds the bit currently on the line at its output end.
  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  // MSB-first words are left-aligned so the top selected bit leaves first.
  always_comb begin
    eff_len  = (in_len == '0 || in_len > FULL_LEN) ? FULL_LEN : in_len;
    pad      = FULL_LEN - eff_len;
    len_mask = {DATA_W{1'b1}} >> pad;
    masked   = in_data & len_mask;
    aligned  = MSB_FIRST ? (in_data << pad) : masked;
    shifted  = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
  end

  assign last_bit = (state == SHIFT) && (bit_cnt == ONE);

`ifdef SER_PARITY_EN
  assign ready_slot = (state == PAR);
`else
  assign ready_slot = last_bit;
`endif

  assign in_ready = !rst && ((state == IDLE) || ready_slot);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next  = state;
    shift_next  = shift_reg;
    cnt_next    = bit_cnt;
    serial_next = IDLE_LEVEL;
    valid_next  = 1'b0;
    busy_next   = 1'b0;
    done_next   = 1'b0;
`ifdef SER_PARITY_EN
    parity_next = parity_reg;
`endif

    if (accept) begin
      state_next  = SHIFT;
      shift_next  = aligned;
      cnt_next    = eff_len;
      serial_next = head_bit(aligned);
      valid_next  = 1'b1;
      busy_next   = 1'b1;
`ifdef SER_PARITY_EN
      parity_next = ^masked;
`else
      done_next   = (eff_len == ONE);
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (bit_cnt > ONE) begin
            shift_next  = shifted;
            cnt_next    = bit_cnt - ONE;
            serial_next = head_bit(shifted);
            valid_next  = 1'b1;
            busy_next   = 1'b1;
`ifndef SER_PARITY_EN
            done_next   = (bit_cnt == TWO);
`endif
          end else begin
            cnt_next   = '0;
            shift_next = '0;
`ifdef SER_PARITY_EN
            state_next  = PAR;
            serial_next = parity_reg;
            valid_next  = 1'b1;
            busy_next   = 1'b1;
            done_next   = 1'b1;
`else
            state_next  = IDLE;
`endif
          end
        end
`ifdef SER_PARITY_EN
        PAR: begin
          state_next = IDLE;
        end
`endif
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Every output except in_ready comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      serial_out <= IDLE_LEVEL;
      bit_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SER_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      bit_cnt    <= cnt_next;
      serial_out <= serial_next;
      bit_valid  <= valid_next;
      busy       <= busy_next;
      done       <= done_next;
`ifdef SER_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Randomised self-checking bench for seq_bit_serializer: MSB-first and LSB-first instances
// are compared every cycle against a queue-of-expected-bits model of the wire.
module tb_seq_bit_serializer;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic [LEN_W-1:0]  in_len = '0;
  logic             in_valid = 1'b0;

  logic m_ready, m_serial, m_valid, m_busy, m_done;
  logic l_ready, l_serial, l_valid, l_busy, l_done;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  exp_t qm[$];
  exp_t ql[$];

  always #5 clk = ~clk;

  seq_bit_serializer #(.DATA_W(DATA_W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
    .in_ready(m_ready), .serial_out(m_serial), .bit_valid(m_valid), .busy(m_busy), .done(m_done)
  );

  seq_bit_serializer #(.DATA_W(DATA_W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
    .in_ready(l_ready), .serial_out(l_serial), .bit_valid(l_valid), .busy(l_busy), .done(l_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected wire content for one accepted word, straight from the length and order rules.
  function automatic void pushWord(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l);
    int  eff;
    logic par;
    bit  par_on;
    exp_t e;
`ifdef SER_PARITY_EN
    par_on = 1'b1;
`else
    par_on = 1'b0;
`endif
    eff = (l == 0 || int'(l) > DATA_W) ? DATA_W : int'(l);
    par = 1'b0;
    for (int i = 0; i < eff; i++) begin
      par = par ^ d[i];
      e.last = (i == eff - 1) && !par_on;
      e.b = d[eff - 1 - i];
      qm.push_back(e);
      e.b = d[i];
      ql.push_back(e);
    end
    if (par_on) begin
      e.b = par;
      e.last = 1'b1;
      qm.push_back(e);
      ql.push_back(e);
    end
  endfunction

  task automatic checkSide(input string tag, input logic so, input logic bv, input logic dn,
                           input logic by, input bit has, input logic eb, input logic el);
    checkOutput({tag, ".bit_valid"}, 32'(bv), 32'(has));
    checkOutput({tag, ".busy"}, 32'(by), 32'(has));
    checkOutput({tag, ".serial_out"}, 32'(so), has ? 32'(eb) : 32'd0);
    checkOutput({tag, ".done"}, 32'(dn), has ? 32'(el) : 32'd0);
  endtask

  // One clock cycle: drive inputs, check in_ready, step the model at the edge, check outputs.
  task automatic applyStimulus(input logic r, input logic v, input logic [DATA_W-1:0] d,
                               input logic [LEN_W-1:0] l, input string tag, output bit accepted);
    logic exp_ready;
    rst = r;
    in_valid = v;
    in_data = d;
    in_len = l;
    #1;
    exp_ready = !r && (qm.size() <= 1);
    checkOutput({tag, ".ready_msb"}, 32'(m_ready), 32'(exp_ready));
    checkOutput({tag, ".ready_lsb"}, 32'(l_ready), 32'(exp_ready));
    accepted = v && exp_ready;
    @(posedge clk);
    if (r) begin
      qm.delete();
      ql.delete();
    end else begin
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (accepted) pushWord(d, l);
    end
    #1;
    if (qm.size() > 0) checkSide({tag, ".msb"}, m_serial, m_valid, m_done, m_busy, 1'b1, qm[0].b, qm[0].last);
    else               checkSide({tag, ".msb"}, m_serial, m_valid, m_done, m_busy, 1'b0, 1'b0, 1'b0);
    if (ql.size() > 0) checkSide({tag, ".lsb"}, l_serial, l_valid, l_done, l_busy, 1'b1, ql[0].b, ql[0].last);
    else               checkSide({tag, ".lsb"}, l_serial, l_valid, l_done, l_busy, 1'b0, 1'b0, 1'b0);
    if (m_done) done_seen++;
  endtask

  task automatic idleCycles(input int n, input string tag);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, tag, acc);
  endtask

  initial begin
    bit acc;
    bit held;
    logic [DATA_W-1:0] got;
    logic [3:0] got_lsb;
    logic r, v;
    logic [DATA_W-1:0] d;
    logic [LEN_W-1:0] l;

    applyStimulus(1'b1, 1'b0, '0, '0, "reset", acc);
    applyStimulus(1'b1, 1'b0, '0, '0, "reset", acc);

    // Single MSB-first word 8'hA5: wire order must rebuild the word.
    applyStimulus(1'b0, 1'b1, 8'hA5, 4'd8, "a5", acc);
    got = {7'd0, m_serial};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, "a5", acc);
      got = {got[6:0], m_serial};
    end
    checkOutput("a5_word", 32'(got), 32'hA5);
    idleCycles(2, "a5_tail");

    // Back-to-back 3-bit words; offers before the last-bit cycle must be ignored.
    done_seen = 0;
    applyStimulus(1'b0, 1'b1, 8'h05, 4'd3, "b2b", acc);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h05, 4'd3, "b2b_offer", acc);
    idleCycles(4, "b2b_tail");
    checkOutput("b2b_done_count", 32'(done_seen), 32'd2);

    applyStimulus(1'b0, 1'b1, 8'h81, 4'd0, "len0", acc);
    idleCycles(9, "len0");
    applyStimulus(1'b0, 1'b1, 8'h81, 4'd12, "len12", acc);
    idleCycles(9, "len12");
    applyStimulus(1'b0, 1'b1, 8'h01, 4'd1, "len1", acc);
    idleCycles(3, "len1");

    // LSB-first 8'h0B over 4 bits reads 1,1,0,1 on the wire.
    applyStimulus(1'b0, 1'b1, 8'h0B, 4'd4, "lsb0b", acc);
    got_lsb = {3'd0, l_serial};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, "lsb0b", acc);
      got_lsb = {got_lsb[2:0], l_serial};
    end
    checkOutput("lsb0b_bits", 32'(got_lsb), 32'b1101);
    idleCycles(3, "lsb0b_tail");

    // Reset in cycle 4 of a word, with a word offered during reset.
    applyStimulus(1'b0, 1'b1, 8'hFF, 4'd8, "rstmid", acc);
    idleCycles(2, "rstmid");
    applyStimulus(1'b1, 1'b1, 8'h3C, 4'd8, "rstmid_rst", acc);
    applyStimulus(1'b1, 1'b1, 8'h3C, 4'd8, "rstmid_rst", acc);
    applyStimulus(1'b0, 1'b1, 8'h3C, 4'd8, "rstmid_after", acc);
    checkOutput("rstmid_accept", 32'(acc), 32'd1);
    idleCycles(10, "rstmid_tail");

    // Random traffic with the upstream holding a word until it is taken.
    held = 1'b0;
    d = '0;
    l = '0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 39) == 0);
      if (held) begin
        v = 1'b1;
      end else begin
        v = ($urandom_range(0, 1) == 1);
        d = DATA_W'($urandom);
        l = LEN_W'($urandom_range(0, 15));
      end
      applyStimulus(r, v, d, l, "rand", acc);
      held = v && !acc;
    end
    idleCycles(12, "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
